// File: rtl/pipe_scoreboard.sv
// Decode-stage interlock: per-register countdown of cycles until each in-flight
// result can be forwarded, plus occupancy of the single non-pipelined unit.
module pipe_scoreboard #(
    parameter int NREG = 32,
    parameter int RW   = 5,
    parameter int LATW = 4,
    parameter int PCW  = 32
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wreg,
    input  logic [RW-1:0]   id_rn,
    input  logic [LATW-1:0] id_lat,
    input  logic            id_unpipe,
    input  logic            flush,
    output logic            stall,
    output logic            rs_ready,
    output logic            rt_ready,
    output logic [NREG-1:0] busy_vec,
    output logic            unit_busy,
    output logic [PCW-1:0]  stall_cnt
);

    logic [LATW-1:0] cnt [NREG];
    logic [LATW-1:0] unit_cnt;
    logic [LATW-1:0] cnt_rs, cnt_rt, cnt_rn;
    logic            raw, waw, struc, issue;

    // cnt[0] is held at zero by the update loop, so a plain index read is safe.
    always_comb begin
        cnt_rs = cnt[id_rs];
        cnt_rt = cnt[id_rt];
        cnt_rn = cnt[id_rn];
    end

    assign raw   = (id_use_rs && cnt_rs != '0) || (id_use_rt && cnt_rt != '0);
    // A younger writer must not finish before an older one to the same register.
    assign waw   = id_wreg && id_rn != '0 && cnt_rn > id_lat;
    assign struc = id_unpipe && unit_cnt != '0;
    assign stall = id_valid && !flush && (raw || waw || struc);
    assign issue = id_valid && !flush && !stall;

    assign rs_ready  = (cnt_rs == '0);
    assign rt_ready  = (cnt_rt == '0);
    assign unit_busy = (unit_cnt != '0);

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0) begin
                    cnt[r] <= '0;
                end else if (issue && id_wreg && id_rn == RW'(r)) begin
                    cnt[r] <= id_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LATW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            unit_cnt <= '0;
        end else if (issue && id_unpipe) begin
            unit_cnt <= id_lat;
        end else if (unit_cnt != '0) begin
            unit_cnt <= unit_cnt - LATW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + PCW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed vectors for pipe_scoreboard; the driver queues the hand-computed
// outputs for each cycle and a negedge monitor pops and compares them.
module tb_pipe_scoreboard;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic        id_wreg = 1'b0;
    logic [4:0]  id_rn = '0;
    logic [3:0]  id_lat = '0;
    logic        id_unpipe = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic        rs_ready;
    logic        rt_ready;
    logic [31:0] busy_vec;
    logic        unit_busy;
    logic [31:0] stall_cnt;

    pipe_scoreboard #(.NREG(32), .RW(5), .LATW(4), .PCW(32)) dut (
        .clock(clock), .resetn(resetn), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wreg(id_wreg), .id_rn(id_rn), .id_lat(id_lat), .id_unpipe(id_unpipe),
        .flush(flush), .stall(stall), .rs_ready(rs_ready), .rt_ready(rt_ready),
        .busy_vec(busy_vec), .unit_busy(unit_busy), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          step;
        logic        stall;
        logic [31:0] busy;
        logic        unit;
        logic [31:0] sc;
        logic        rsr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   step_no = 0;

    task automatic chk(input string nm, input int st, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s step %0d got %h want %h", nm, st, act, want);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall",     e.step, {31'd0, stall},     {31'd0, e.stall});
            chk("busy_vec",  e.step, busy_vec,           e.busy);
            chk("unit_busy", e.step, {31'd0, unit_busy}, {31'd0, e.unit});
            chk("stall_cnt", e.step, stall_cnt,          e.sc);
            chk("rs_ready",  e.step, {31'd0, rs_ready},  {31'd0, e.rsr});
        end
    end

    // One D-stage cycle: drive inputs just after the edge, queue the expected outputs.
    task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wr,
                       input logic [4:0] rn, input logic [3:0] lat,
                       input logic up, input logic fl, input logic rb,
                       input logic e_stall, input logic [31:0] e_busy,
                       input logic e_unit, input logic [31:0] e_sc, input logic e_rsr);
        exp_t e;
        @(posedge clock);
        #1;
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wreg = wr; id_rn = rn; id_lat = lat; id_unpipe = up; flush = fl;
        resetn = rb;
        e.step = step_no; e.stall = e_stall; e.busy = e_busy; e.unit = e_unit;
        e.sc = e_sc; e.rsr = e_rsr;
        exp_q.push_back(e);
        step_no++;
    endtask

    task automatic idle(input logic [31:0] e_busy, input logic e_unit, input logic [31:0] e_sc);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, e_busy, e_unit, e_sc, 1);
    endtask

    initial begin
        // reset
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        // load r2 lat1, dependant reads r2 through rt
        cyc(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1,  0, 0, 0, 0, 1);
        cyc(1, 0, 2, 0, 1, 1, 3, 0, 0, 0, 1,  1, 32'h4, 0, 0, 1);
        cyc(1, 0, 2, 0, 1, 1, 3, 0, 0, 0, 1,  0, 0, 0, 1, 1);
        idle(0, 0, 1);
        // ALU producer, ALU consumer: never stalls
        cyc(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1,  0, 0, 0, 1, 1);
        cyc(1, 2, 0, 1, 0, 1, 4, 0, 0, 0, 1,  0, 0, 0, 1, 1);
        // div r5 lat8, second div blocked on the unit for 8 cycles
        cyc(1, 0, 0, 0, 0, 1, 5, 8, 1, 0, 1,  0, 0, 0, 1, 1);
        for (int k = 0; k < 8; k++)
            cyc(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 1,  1, 32'h20, 1, 32'(1 + k), 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 1,  0, 0, 0, 9, 1);
        for (int k = 0; k < 8; k++) idle(0, 1, 9);
        idle(0, 0, 9);
        // WAW: mul r6 lat4 then ALU write r6
        cyc(1, 0, 0, 0, 0, 1, 6, 4, 0, 0, 1,  0, 0, 0, 9, 1);
        for (int k = 0; k < 4; k++)
            cyc(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 1,  1, 32'h40, 0, 32'(9 + k), 1);
        cyc(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 1,  0, 0, 0, 13, 1);
        // WAW boundary: stall only while cnt > id_lat, equal is allowed
        cyc(1, 0, 0, 0, 0, 1, 6, 4, 0, 0, 1,  0, 0, 0, 13, 1);
        cyc(1, 0, 0, 0, 0, 1, 6, 3, 0, 0, 1,  1, 32'h40, 0, 13, 1);
        cyc(1, 0, 0, 0, 0, 1, 6, 3, 0, 0, 1,  0, 32'h40, 0, 14, 1);
        for (int k = 0; k < 3; k++) idle(32'h40, 0, 14);
        idle(0, 0, 14);
        // r0 writes ignored
        cyc(1, 0, 0, 0, 0, 1, 0, 5, 0, 0, 1,  0, 0, 0, 14, 1);
        cyc(1, 0, 0, 1, 1, 1, 3, 0, 0, 0, 1,  0, 0, 0, 14, 1);
        idle(0, 0, 14);
        // flush suppresses stall but the counter keeps running
        cyc(1, 0, 0, 0, 0, 1, 2, 3, 0, 0, 1,  0, 0, 0, 14, 1);
        cyc(1, 2, 0, 1, 0, 1, 3, 0, 0, 1, 1,  0, 32'h4, 0, 14, 0);
        cyc(1, 2, 0, 1, 0, 1, 3, 0, 0, 0, 1,  1, 32'h4, 0, 14, 0);
        cyc(1, 2, 0, 1, 0, 1, 3, 0, 0, 0, 1,  1, 32'h4, 0, 15, 0);
        cyc(1, 2, 0, 1, 0, 1, 3, 0, 0, 0, 1,  0, 0, 0, 16, 1);
        // async reset in the middle of a div-blocked stall
        cyc(1, 0, 0, 0, 0, 1, 5, 8, 1, 0, 1,  0, 0, 0, 16, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 1,  1, 32'h20, 1, 16, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0,  0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 1,  0, 0, 0, 0, 1);
        idle(0, 1, 0);

        @(posedge clock);
        @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
